ddr_tx_serializer: RTL and testbench

Transmit-side counterpart of the DDR input capture path: accepts parallel words over a valid/ready handshake and serializes them MSB-first onto one output pin at two bits per clock, one on each clock phase. Sits between the link/frame logic and the output pad. A receiver built on the team's DDR input register recovers the stream as (dataout_h, dataout_l) pairs. A one-entry holding register allows gapless back-to-back words.

---
 rtl/ddr_link_pkg.sv | 23 ++
 rtl/ddr_tx_serializer_oddr_cell.sv | 37 +++
 rtl/ddr_tx_serializer.sv | 119 +++++++++++
 tb/tb_ddr_tx_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_link_pkg.sv
// Shared types and constants for the DDR link serializer and its matching receiver.
// Both sides use the same idle pin level.
package ddr_link_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

  // Width of a down-counter that indexes the pairs of one word (minimum one bit).
  function automatic int pair_cnt_width(input int word_w);
    int pairs;
    pairs = word_w / 2;
    if (pairs > 1) begin
      return $clog2(pairs);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ddr_tx_serializer_oddr_cell.sv
// Output DDR cell: registers a (h, l) pair on the rising edge and muxes it onto one pin.
// Synthesis maps this cell to the vendor ODDR primitive.
module oddr_cell
  import ddr_link_pkg::*;
#(
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic inclock,
  input  logic aclr,
  input  logic d_h,
  input  logic d_l,
  output logic dataout
);

  logic h_q_r;
  logic l_q_r;
  logic l_neg_r;

  // Rising-edge pair capture with synchronous reset to the idle level
  always_ff @(posedge inclock) begin
    if (aclr) begin
      h_q_r <= IDLE_LEVEL;
      l_q_r <= IDLE_LEVEL;
    end else begin
      h_q_r <= d_h;
      l_q_r <= d_l;
    end
  end

  // Low-phase bit is retimed to the falling edge so the pin mux cannot glitch mid-phase
  always_ff @(negedge inclock) begin
    l_neg_r <= l_q_r;
  end

  assign dataout = inclock ? h_q_r : l_neg_r;

endmodule

// File: rtl/ddr_tx_serializer.sv
// DDR transmit serializer: parallel words in over valid/ready, MSB-first out at two bits per clock.
// A one-entry holding register in front of the shifter allows gapless back-to-back words.
module ddr_tx_serializer
  import ddr_link_pkg::*;
#(
  parameter int   WORD_W     = 12,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic              inclock,
  input  logic              aclr,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dataout,
  output logic              busy,
  output logic              word_done
);

  localparam int              PAIRS    = WORD_W / 2;
  localparam int              CNT_W    = pair_cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAIRS - 1);

  tx_state_e         state_r;
  logic [WORD_W-1:0] shift_r;
  logic [WORD_W-1:0] hold_data_r;
  logic              hold_full_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              word_done_r;

  logic accept_s;
  logic last_pair_s;
  logic hold_take_s;
  logic direct_load_s;
  logic pair_h_s;
  logic pair_l_s;

  assign tx_ready  = !hold_full_r && !aclr;
  assign accept_s  = tx_valid && tx_ready;
  assign busy      = (state_r == ST_SHIFT);
  assign word_done = word_done_r;

  // Pair presented to the DDR cell, and where the next shifter word comes from
  always_comb begin
    pair_h_s      = IDLE_LEVEL;
    pair_l_s      = IDLE_LEVEL;
    last_pair_s   = 1'b0;
    hold_take_s   = 1'b0;
    direct_load_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      pair_h_s      = shift_r[WORD_W-1];
      pair_l_s      = shift_r[WORD_W-2];
      last_pair_s   = (cnt_r == {CNT_W{1'b0}});
      hold_take_s   = last_pair_s && hold_full_r;
      // Same-edge accept on the last pair bypasses the holding register
      direct_load_s = last_pair_s && !hold_full_r && accept_s;
    end else begin
      hold_take_s   = hold_full_r;
    end
  end

  // Shifter state machine, pair counter and holding register
  always_ff @(posedge inclock) begin
    if (aclr) begin
      state_r     <= ST_IDLE;
      shift_r     <= {WORD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      hold_data_r <= {WORD_W{1'b0}};
      hold_full_r <= 1'b0;
      word_done_r <= 1'b0;
    end else begin
      word_done_r <= last_pair_s;
      case (state_r)
        ST_IDLE: begin
          if (hold_take_s) begin
            shift_r <= hold_data_r;
            cnt_r   <= LAST_CNT;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (hold_take_s) begin
            shift_r <= hold_data_r;
            cnt_r   <= LAST_CNT;
          end else if (direct_load_s) begin
            shift_r <= tx_data;
            cnt_r   <= LAST_CNT;
          end else if (last_pair_s) begin
            shift_r <= {WORD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_IDLE;
          end else begin
            shift_r <= {shift_r[WORD_W-3:0], 2'b00};
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (accept_s && !direct_load_s) begin
        hold_data_r <= tx_data;
        hold_full_r <= 1'b1;
      end else if (hold_take_s) begin
        hold_full_r <= 1'b0;
      end
    end
  end

  oddr_cell #(
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_oddr (
    .inclock (inclock),
    .aclr    (aclr),
    .d_h     (pair_h_s),
    .d_l     (pair_l_s),
    .dataout (dataout)
  );

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Self-checking bench for ddr_tx_serializer: word-queue reference model with per-cycle compare,
// an IDDR-style loopback reassembler, and directed scenarios pinned with literal expectations.
module tb_ddr_tx_serializer;

  localparam int   W     = 12;
  localparam int   PAIRS = W / 2;
  localparam logic IDLE  = 1'b1;
  localparam int   LOGN  = 4096;

  logic         inclock;
  logic         aclr;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         dataout;
  logic         busy;
  logic         word_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = -1;
  bit m_acc  = 1'b0;

  logic h_log     [0:LOGN-1];
  logic l_log     [0:LOGN-1];
  logic done_log  [0:LOGN-1];
  logic busy_log  [0:LOGN-1];
  logic ready_log [0:LOGN-1];

  logic [W-1:0] hold_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] cur_word;
  int           cur_left = 0;
  int           rx_cnt   = 0;
  int           rx_words = 0;
  logic [W-1:0] rx_word;

  ddr_tx_serializer #(.WORD_W(W), .IDLE_LEVEL(IDLE)) dut (
    .inclock   (inclock),
    .aclr      (aclr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dataout   (dataout),
    .busy      (busy),
    .word_done (word_done)
  );

  initial begin
    inclock = 1'b0;
    forever #5 inclock = ~inclock;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] grab(input int c0, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = {v[29:0], h_log[c0+i], l_log[c0+i]};
    return v;
  endfunction

  function automatic logic [31:0] grab_done(input int c0, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = {v[30:0], done_log[c0+i]};
    return v;
  endfunction

  // Reference model: words flow accept -> hold queue -> current word, PAIRS cycles each.
  initial begin
    logic         a, v;
    logic [W-1:0] d;
    logic         exp_h, exp_l, exp_done, h_act;
    logic [W-1:0] exp_w;
    bit           direct, data_pair;
    int           idx;
    forever begin
      @(posedge inclock);
      cyc++;
      a = aclr; v = tx_valid; d = tx_data;
      direct = 1'b0; data_pair = 1'b0; exp_done = 1'b0;
      exp_h = IDLE; exp_l = IDLE;
      if (a) begin
        hold_q.delete();
        rx_q.delete();
        cur_left = 0;
        rx_cnt = 0;
        m_acc = 1'b0;
      end else begin
        m_acc = v && (hold_q.size() == 0);
        if (cur_left > 0) begin
          idx = PAIRS - cur_left;
          exp_h = cur_word[W-1-2*idx];
          exp_l = cur_word[W-2-2*idx];
          data_pair = 1'b1;
          cur_left--;
          if (cur_left == 0) begin
            exp_done = 1'b1;
            if (hold_q.size() > 0) begin
              cur_word = hold_q.pop_front();
              cur_left = PAIRS;
            end else if (m_acc) begin
              cur_word = d;
              cur_left = PAIRS;
              direct = 1'b1;
            end
          end
        end else if (hold_q.size() > 0) begin
          cur_word = hold_q.pop_front();
          cur_left = PAIRS;
        end
        if (m_acc && !direct) hold_q.push_back(d);
        if (m_acc) begin
          rx_q.push_back(d);
          acc_cyc = cyc;
        end
      end
      #2;
      h_act = dataout;
      chk("pin_h", h_act, exp_h);
      chk("busy", busy, cur_left > 0);
      chk("word_done", word_done, exp_done);
      chk("tx_ready", tx_ready, (hold_q.size() == 0) && !aclr);
      if (cyc < LOGN) begin
        h_log[cyc] = h_act;
        done_log[cyc] = word_done;
        busy_log[cyc] = busy;
        ready_log[cyc] = tx_ready;
      end
      @(negedge inclock);
      #2;
      chk("pin_l", dataout, exp_l);
      if (cyc < LOGN) l_log[cyc] = dataout;
      // Receiver side: reassemble captured (h, l) pairs into words
      if (data_pair) begin
        rx_word = {rx_word[W-3:0], h_act, dataout};
        rx_cnt++;
        if (rx_cnt == PAIRS) begin
          rx_cnt = 0;
          rx_words++;
          chk("loopback_pending", rx_q.size() > 0, 1'b1);
          if (rx_q.size() > 0) begin
            exp_w = rx_q.pop_front();
            chk("loopback_word", rx_word, exp_w);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge inclock);
      #1;
    end
  endtask

  // Drives a word and returns the cycle of its accept edge; leaves tx_valid high.
  task automatic send(input logic [W-1:0] w, output int k);
    int n;
    tx_data = w;
    tx_valid = 1'b1;
    n = 0;
    k = -1;
    while (k < 0 && n < 50) begin
      @(posedge inclock);
      #1;
      n++;
      if (m_acc) k = acc_cyc;
    end
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h not accepted within 50 cycles", w);
      k = cyc;
    end
  endtask

  initial begin
    int k, k2, rx_start;
    aclr = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    repeat (2) begin
      @(posedge inclock);
      #1;
    end
    aclr = 1'b0;
    wait_cyc(4);
    chk("reset_ready_low", ready_log[1], 1'b0);
    chk("reset_busy", busy_log[1], 1'b0);
    chk("reset_done", done_log[1], 1'b0);
    chk("reset_pin", {h_log[1], l_log[1]}, 2'b11);
    chk("post_reset_ready", ready_log[2], 1'b1);

    // Single word 0xA5C
    send(12'hA5C, k);
    tx_valid = 1'b0;
    wait_cyc(k + 10);
    chk("t1_idle_before", {h_log[k+1], l_log[k+1]}, 2'b11);
    chk("t1_pins", grab(k + 2, 6), 32'h00000A5C);
    chk("t1_done_pattern", grab_done(k + 2, 7), 32'h02);
    chk("t1_busy_last", busy_log[k+6], 1'b1);
    chk("t1_busy_clear", busy_log[k+7], 1'b0);
    chk("t1_idle_after", {h_log[k+8], l_log[k+8]}, 2'b11);
    chk("t1_ready_after_accept", ready_log[k], 1'b0);
    chk("t1_ready_drained", ready_log[k+1], 1'b1);

    // Back-to-back 0xFFF, 0x000 with tx_valid held
    send(12'hFFF, k);
    send(12'h000, k2);
    tx_valid = 1'b0;
    wait_cyc(k + 16);
    chk("t2_second_accept", k2 - k, 2);
    chk("t2_pins", grab(k + 2, 12), 32'h00FFF000);
    chk("t2_done_pattern", grab_done(k + 2, 13), 32'h0082);
    chk("t2_ready_held", ready_log[k+2], 1'b0);
    chk("t2_ready_drain", ready_log[k+7], 1'b1);

    // Accept landing exactly on the last-pair edge
    send(12'h3C6, k);
    tx_valid = 1'b0;
    wait_cyc(k + 6);
    send(12'h9A1, k2);
    tx_valid = 1'b0;
    wait_cyc(k + 18);
    chk("t3_accept_edge", k2 - k, 7);
    chk("t3_pins", grab(k + 2, 12), 32'h003C69A1);
    chk("t3_hold_empty", ready_log[k+7], 1'b1);
    chk("t3_done_pattern", grab_done(k + 2, 13), 32'h0082);
    chk("t3_no_dup_busy", busy_log[k+13], 1'b0);
    chk("t3_idle_after", {h_log[k+14], l_log[k+14]}, 2'b11);

    // Reset during the third pair of 0x555, then 0x0F0
    send(12'h555, k);
    tx_valid = 1'b0;
    wait_cyc(k + 4);
    aclr = 1'b1;
    wait_cyc(k + 5);
    aclr = 1'b0;
    send(12'h0F0, k2);
    tx_valid = 1'b0;
    wait_cyc(k2 + 10);
    chk("t4_first_pairs", grab(k + 2, 3), 32'h15);
    chk("t4_ready_in_reset", ready_log[k+4], 1'b0);
    chk("t4_pin_idle", {h_log[k+5], l_log[k+5]}, 2'b11);
    chk("t4_busy_cleared", busy_log[k+5], 1'b0);
    chk("t4_ready_after", ready_log[k+5], 1'b1);
    chk("t4_no_done", grab_done(k + 2, 4), 32'h0);
    chk("t4_next_accept", k2 - k, 6);
    chk("t4_next_pins", grab(k2 + 2, 6), 32'h000000F0);

    // Loopback: random words with random gaps
    rx_start = rx_words;
    for (int i = 0; i < 1000; i++) begin
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge inclock);
        #1;
      end
      send(W'($urandom_range(0, 4095)), k);
    end
    tx_valid = 1'b0;
    wait_cyc(cyc + 20);
    chk("loopback_count", rx_words - rx_start, 1000);
    chk("loopback_drained", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
